alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Downstream stage of the ALU: captures each ALU result and its status outputs, updates the CPU flags register (Z, N, C, V), and buffers non-compare results in a 2-entry queue for register-file write-back. The registered carry flag is fed back as the ALU carry input for multi-byte arithmetic. A 3-bit condition code is evaluated against the current flags to produce the jump-taken signal for the control unit.

## Interface
Parameters
- DEPTH, 2, result queue entries; only 2 is supported.

Ports
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU output valid this cycle; acts as the push strobe
- alu_ready  out  1  stage can accept; equals (count < DEPTH)
- alu_data  in  8  ALU result byte
- alu_carry  in  1  ALU carry-out
- alu_over  in  1  ALU signed overflow
- alu_cmp  in  1  compare-only operation: update the flags, do not enqueue
- carry_flag  out  1  registered C; drives the ALU carry input
- zero_flag, neg_flag, over_flag  out  1 each  registered Z, N, V
- clr_carry  in  1  force C to 0 (start of a multi-byte chain)
- cond  in  3  jump condition select
- jmp_take  out  1  combinational condition result from the registered flags
- res_data  out  8  queue head
- res_valid  out  1  queue non-empty
- res_ready  in  1  write-back consumer accepts the head

## Operation
- Accept = alu_valid & alu_ready. On accept:
  - Z <= (alu_data == 0); N <= alu_data[7]; C <= alu_carry; V <= alu_over.
  - If alu_cmp = 0, push alu_data.
- The flags update on accept even when alu_cmp = 1.
- A push that is not accepted has no effect on the flags or the queue.
- clr_carry forces C to 0. If it coincides with an accept, clr_carry wins for C only; Z, N and V still update.
- Pop = res_valid & res_ready. The head advances and the count decrements.
- Push and pop in the same cycle: the count is unchanged and the data order is preserved. This can only occur when the count is 1, or when the count is 2 with pop only, because alu_ready = 0 at count 2.
- Pop when the queue is empty: ignored.
- Queue: 2 entries, 1-bit read pointer, 1-bit write pointer, 2-bit count. Pointers wrap modulo 2.
- Condition codes:
  - 0: always
  - 1: Z
  - 2: !Z
  - 3: C
  - 4: !C
  - 5: N
  - 6: V
  - 7: N^V (signed less-than)
- jmp_take reflects the flags as registered. It does not see a same-cycle accept.

## Timing
- Reset values: Z = 0, N = 0, C = 0, V = 0, count = 0, pointers = 0.
  - Resulting outputs: res_valid = 0, res_data = 0, alu_ready = 1, jmp_take = (cond == 0).
- Reset applied mid-operation discards queued data in that cycle.
- Flags are visible on the outputs 1 cycle after the accepting edge.
- Result latency, default build: res_valid rises 1 cycle after the accept.
- Throughput: 1 accept per cycle while res_ready is held high.
- alu_ready depends only on the registered count. There is no combinational path from res_ready to alu_ready.

## Configuration
- ALU_STAGE_BYPASS_EN defined:
  - When the queue is empty and alu_cmp = 0, res_valid = alu_valid and res_data = alu_data combinationally.
  - If res_ready is also high, the result is consumed without being written into the queue (0-cycle latency).
  - If res_ready is low, the result is enqueued normally.
- ALU_STAGE_BYPASS_EN undefined: no combinational input-to-output path; every result passes through the queue.

## Structure
- Shared package jrb8_pkg:
  - cond_e encodings (COND_ALW, COND_Z, COND_NZ, COND_C, COND_NC, COND_N, COND_V, COND_LT).
  - Flag bit-index constants FLAG_Z, FLAG_N, FLAG_C, FLAG_V.
- Sub-module result_fifo2: the 2-entry queue (push, pop, count, head), instantiated once.
- The flags register and the condition mux stay in the top module.

## Test plan
- After reset, cond = 0 -> jmp_take = 1; all flags 0; alu_ready = 1; res_valid = 0.
- Accept alu_data = 0x00, alu_carry = 1, alu_over = 0 -> next cycle Z = 1, C = 1, N = 0; res_data = 0x00 with res_valid = 1.
- Accept 0x80 with alu_over = 1 and alu_cmp = 1 -> N = 1, V = 1; the queue stays empty; cond = 7 -> jmp_take = 0.
- res_ready = 0, accept 0x11 then 0x22 -> alu_ready = 0. A third push of 0x33 is ignored. Raising res_ready pops 0x11, then 0x22, in order.
- Count = 1 (head 0x44): push 0x55 and pop in the same cycle -> count stays 1, next head = 0x55.
- clr_carry together with an accept where alu_carry = 1 -> C = 0 while Z, N and V update; assert rst mid-queue -> res_valid = 0 on the next cycle.

Source files
------------

// File: rtl/jrb8_pkg.sv
// Shared definitions for the jrb8 CPU: jump condition encodings and flag bit indices.
package jrb8_pkg;

  typedef enum logic [2:0] {
    COND_ALW = 3'd0,
    COND_Z   = 3'd1,
    COND_NZ  = 3'd2,
    COND_C   = 3'd3,
    COND_NC  = 3'd4,
    COND_N   = 3'd5,
    COND_V   = 3'd6,
    COND_LT  = 3'd7
  } cond_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry result queue with wrapping 1-bit pointers and a 2-bit occupancy count.
module result_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [1:0] count
);

  logic [7:0] mem [2];
  logic       rptr;
  logic       wptr;
  logic       pop_eff;

  // Popping an empty queue is a no-op.
  assign pop_eff = pop & (count != 2'd0);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      rptr   <= 1'b0;
      wptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (pop_eff)
        rptr <= ~rptr;
      case ({push, pop_eff})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: flags register, jump condition mux and write-back queue.
// Optional zero-latency bypass when ALU_STAGE_BYPASS_EN is defined.
module alu_result_stage
  import jrb8_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_valid,
  output logic       alu_ready,
  input  logic [7:0] alu_data,
  input  logic       alu_carry,
  input  logic       alu_over,
  input  logic       alu_cmp,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       neg_flag,
  output logic       over_flag,
  input  logic       clr_carry,
  input  logic [2:0] cond,
  output logic       jmp_take,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready
);

  logic [3:0] flags;
  logic [1:0] count;
  logic [7:0] head;
  logic       accept;
  logic       push;
  logic       fifo_valid;

  assign alu_ready  = (count < DEPTH[1:0]) | (DEPTH > 3);
  assign accept     = alu_valid & alu_ready;
  assign fifo_valid = (count != 2'd0);

`ifdef ALU_STAGE_BYPASS_EN
  logic bypass;
  // A result headed for an empty queue is offered straight to write-back.
  assign bypass    = ~fifo_valid & alu_valid & ~alu_cmp;
  assign res_valid = fifo_valid | bypass;
  assign res_data  = fifo_valid ? head : (bypass ? alu_data : head);
  assign push      = accept & ~alu_cmp & ~(bypass & res_ready);
`else
  assign res_valid = fifo_valid;
  assign res_data  = head;
  assign push      = accept & ~alu_cmp;
`endif

  result_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (res_ready & fifo_valid),
    .din   (alu_data),
    .dout  (head),
    .count (count)
  );

  // clr_carry overrides only C; the other flags still follow an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else begin
      if (accept) begin
        flags[FLAG_Z] <= (alu_data == 8'h00);
        flags[FLAG_N] <= alu_data[7];
        flags[FLAG_V] <= alu_over;
      end
      if (clr_carry)
        flags[FLAG_C] <= 1'b0;
      else if (accept)
        flags[FLAG_C] <= alu_carry;
    end
  end

  assign zero_flag  = flags[FLAG_Z];
  assign neg_flag   = flags[FLAG_N];
  assign carry_flag = flags[FLAG_C];
  assign over_flag  = flags[FLAG_V];

  always_comb begin
    jmp_take = 1'b0;
    case (cond_e'(cond))
      COND_ALW: jmp_take = 1'b1;
      COND_Z:   jmp_take = flags[FLAG_Z];
      COND_NZ:  jmp_take = ~flags[FLAG_Z];
      COND_C:   jmp_take = flags[FLAG_C];
      COND_NC:  jmp_take = ~flags[FLAG_C];
      COND_N:   jmp_take = flags[FLAG_N];
      COND_V:   jmp_take = flags[FLAG_V];
      COND_LT:  jmp_take = flags[FLAG_N] ^ flags[FLAG_V];
      default:  jmp_take = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (default build, bypass disabled).
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid;
  logic       alu_ready;
  logic [7:0] alu_data;
  logic       alu_carry;
  logic       alu_over;
  logic       alu_cmp;
  logic       carry_flag;
  logic       zero_flag;
  logic       neg_flag;
  logic       over_flag;
  logic       clr_carry;
  logic [2:0] cond;
  logic       jmp_take;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;

  int compareCount = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_data   (alu_data),
    .alu_carry  (alu_carry),
    .alu_over   (alu_over),
    .alu_cmp    (alu_cmp),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag),
    .over_flag  (over_flag),
    .clr_carry  (clr_carry),
    .cond       (cond),
    .jmp_take   (jmp_take),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c,
                               input logic o, input logic cmp);
    alu_valid = v;
    alu_data  = d;
    alu_carry = c;
    alu_over  = o;
    alu_cmp   = cmp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlags(input string tag, input logic z, input logic n, input logic c, input logic v);
    checkOutput({tag, ".Z"}, {7'd0, zero_flag},  {7'd0, z});
    checkOutput({tag, ".N"}, {7'd0, neg_flag},   {7'd0, n});
    checkOutput({tag, ".C"}, {7'd0, carry_flag}, {7'd0, c});
    checkOutput({tag, ".V"}, {7'd0, over_flag},  {7'd0, v});
  endtask

  task automatic checkCond(input string tag, input logic [2:0] c, input logic expected);
    cond = c;
    #1;
    checkOutput(tag, {7'd0, jmp_take}, {7'd0, expected});
  endtask

  initial begin
    rst = 1'b1;
    clr_carry = 1'b0;
    cond = 3'd0;
    res_ready = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;

    checkCond("rst_jmp_alw", 3'd0, 1'b1);
    checkCond("rst_jmp_z", 3'd1, 1'b0);
    checkFlags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_ready", {7'd0, alu_ready}, 8'd1);
    checkOutput("rst_rvalid", {7'd0, res_valid}, 8'd0);
    checkOutput("rst_rdata", res_data, 8'h00);

    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkFlags("zero", 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("zero_rvalid", {7'd0, res_valid}, 8'd1);
    checkOutput("zero_rdata", res_data, 8'h00);
    checkCond("zero_jmp_z", 3'd1, 1'b1);
    checkCond("zero_jmp_nc", 3'd4, 1'b0);
    checkCond("zero_jmp_c", 3'd3, 1'b1);
    res_ready = 1'b1;
    step();
    checkOutput("zero_popped", {7'd0, res_valid}, 8'd0);
    step();
    checkOutput("empty_pop_ignored", {7'd0, res_valid}, 8'd0);
    checkOutput("empty_pop_ready", {7'd0, alu_ready}, 8'd1);
    res_ready = 1'b0;

    applyStimulus(1'b1, 8'h80, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkFlags("cmp", 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("cmp_no_enqueue", {7'd0, res_valid}, 8'd0);
    checkCond("cmp_jmp_lt", 3'd7, 1'b0);
    checkCond("cmp_jmp_n", 3'd5, 1'b1);
    checkCond("cmp_jmp_v", 3'd6, 1'b1);
    checkCond("cmp_jmp_nz", 3'd2, 1'b1);

    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("fill1_ready", {7'd0, alu_ready}, 8'd1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("full_ready", {7'd0, alu_ready}, 8'd0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkFlags("full_push_ignored", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_head", res_data, 8'h11);
    res_ready = 1'b1;
    step();
    checkOutput("pop1_valid", {7'd0, res_valid}, 8'd1);
    checkOutput("pop1_head", res_data, 8'h22);
    step();
    checkOutput("pop2_valid", {7'd0, res_valid}, 8'd0);
    res_ready = 1'b0;

    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("one_head", res_data, 8'h44);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    res_ready = 1'b1;
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("pushpop_valid", {7'd0, res_valid}, 8'd1);
    checkOutput("pushpop_ready", {7'd0, alu_ready}, 8'd1);
    checkOutput("pushpop_head", res_data, 8'h55);
    step();
    checkOutput("pushpop_drain", {7'd0, res_valid}, 8'd0);
    res_ready = 1'b0;

    clr_carry = 1'b1;
    applyStimulus(1'b1, 8'h90, 1'b1, 1'b1, 1'b0);
    step();
    clr_carry = 1'b0;
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    checkFlags("clr", 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_head", res_data, 8'h90);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_ready", {7'd0, alu_ready}, 8'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid_rst_valid", {7'd0, res_valid}, 8'd0);
    checkOutput("mid_rst_data", res_data, 8'h00);
    checkOutput("mid_rst_ready", {7'd0, alu_ready}, 8'd1);
    checkFlags("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
